// File: rtl/light_pkg.sv
// Shared mode constants, press FSM state type and default parameters for the lighting path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package light_pkg;

    localparam int DEF_N_CH              = 2;
    localparam int DEF_NUM_MODES         = 4;
    localparam int DEF_DEBOUNCE_CYCLES   = 4;
    localparam int DEF_LONG_PRESS_CYCLES = 16;

    localparam int unsigned NATURAL = 0;
    localparam int unsigned WHITE   = 1;
    localparam int unsigned BLUE    = 2;
    localparam int unsigned ORANGE  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } press_state_t;

endpackage

// File: rtl/btn_press_classifier.sv
// One button channel: 2-flop sync, debounce, short/long press classification.
// Latency: btn edge to debounced level 2+DEBOUNCE_CYCLES; events decode from registered state.
// Backpressure: none; events are single-cycle pulses that must be consumed immediately.
module btn_press_classifier
    import light_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic short_evt,
    output logic long_evt
);

    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int HCNT_W = $clog2(LONG_PRESS_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_PRESS_CYCLES - 1);

    logic               sync_q1;
    logic               sync;
    logic               db;
    logic [DCNT_W-1:0]  dcnt;
    logic [HCNT_W-1:0]  hcnt;
    press_state_t       state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b0;
            sync    <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync    <= sync_q1;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db   <= 1'b0;
            dcnt <= '0;
        end else if (sync == db) begin
            dcnt <= '0;
        end else if (dcnt == DCNT_LAST) begin
            db   <= sync;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            hcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (db) begin
                        state <= PRESSED;
                        hcnt  <= '0;
                    end
                end
                PRESSED: begin
                    if (!db) begin
                        state <= IDLE;
                    end else if (hcnt == HCNT_LAST) begin
                        state <= HELD;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!db) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded from registers only, so the mode register can act on the same edge the FSM leaves PRESSED.
    assign short_evt = (state == PRESSED) && !db;
    assign long_evt  = (state == PRESSED) && db && (hcnt == HCNT_LAST);

endmodule

// File: rtl/light_mode_sel.sv
// Per-channel lighting mode selector: short press steps mode with wrap, long press returns to NATURAL.
// Latency: mode/pulses registered one cycle after the classifier event (DEBOUNCE_CYCLES+3 from release).
// Backpressure: none; channels are independent and every event is applied on the cycle it occurs.
module light_mode_sel
    import light_pkg::*;
#(
    parameter int N_CH              = DEF_N_CH,
    parameter int NUM_MODES         = DEF_NUM_MODES,
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    localparam int MODE_W           = $clog2(NUM_MODES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          btn,
    output logic [N_CH*MODE_W-1:0]   mode,
    output logic [N_CH-1:0]          mode_change,
    output logic [N_CH-1:0]          long_press
);

    localparam logic [MODE_W-1:0] MODE_LAST    = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W-1:0] MODE_NATURAL = MODE_W'(NATURAL);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic              short_evt;
        logic              long_evt;
        logic [MODE_W-1:0] mode_q;
        logic              mc_q;
        logic              lp_q;

        btn_press_classifier #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
        ) u_cls (
            .clk       (clk),
            .reset     (reset),
            .btn       (btn[g]),
            .short_evt (short_evt),
            .long_evt  (long_evt)
        );

        // ">=" rather than "==" so an out-of-range value is pulled back to NATURAL by the next step.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mode_q <= MODE_NATURAL;
                mc_q   <= 1'b0;
                lp_q   <= 1'b0;
            end else begin
                mc_q <= 1'b0;
                lp_q <= 1'b0;
                if (long_evt) begin
                    mode_q <= MODE_NATURAL;
                    lp_q   <= 1'b1;
                    mc_q   <= (mode_q != MODE_NATURAL);
                end else if (short_evt) begin
                    mode_q <= (mode_q >= MODE_LAST) ? MODE_NATURAL : mode_q + 1'b1;
                    mc_q   <= 1'b1;
                end
            end
        end

        assign mode[g*MODE_W +: MODE_W] = mode_q;
        assign mode_change[g]           = mc_q;
        assign long_press[g]            = lp_q;
    end

endmodule
